// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM access arbiter.
// FSM state encoding, default bus widths and requester ids.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    TURN
  } state_e;

endpackage

// File: rtl/sram_arb_if.sv
// Requester-side bus of the SRAM arbiter: port 0 reads, port 1 reads/writes.
// master = requesters, slave = arbiter.
interface sram_arb_if #(
  parameter int ADDR_W = sram_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W = sram_arb_pkg::DATA_W_DEF
);

  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic              p0_gnt;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_rvalid;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [1:0]        p1_be;
  logic              p1_gnt;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_rvalid;

  modport master (
    output p0_req, p0_addr,
    input  p0_gnt, p0_rdata, p0_rvalid,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_be,
    input  p1_gnt, p1_rdata, p1_rvalid
  );

  modport slave (
    input  p0_req, p0_addr,
    output p0_gnt, p0_rdata, p0_rvalid,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_be,
    output p1_gnt, p1_rdata, p1_rvalid
  );

endinterface

// File: rtl/sram_pin_io.sv
// Registered SRAM pin drivers and DQ tristate.
// Every strobe/address leaves a flop so the pins are glitch-free.
module sram_pin_io
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce_n_d,
  input  logic              oe_n_d,
  input  logic              we_n_d,
  input  logic              lb_n_d,
  input  logic              ub_n_d,
  input  logic              dq_oe_d,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] dq_out_d,
  output logic              ce_n,
  output logic              oe_n,
  output logic              we_n,
  output logic              lb_n,
  output logic              ub_n,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dq_in,
  inout  wire  [DATA_W-1:0] dq
);

  logic              ce_n_q;
  logic              oe_n_q;
  logic              we_n_q;
  logic              lb_n_q;
  logic              ub_n_q;
  logic              dq_oe_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dq_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      addr_q   <= '0;
      dq_out_q <= '0;
    end else begin
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      lb_n_q   <= lb_n_d;
      ub_n_q   <= ub_n_d;
      dq_oe_q  <= dq_oe_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
    end
  end

  assign ce_n  = ce_n_q;
  assign oe_n  = oe_n_q;
  assign we_n  = we_n_q;
  assign lb_n  = lb_n_q;
  assign ub_n  = ub_n_q;
  assign addr  = addr_q;
  assign dq    = dq_oe_q ? dq_out_q : 'z;
  assign dq_in = dq;

endmodule

// File: rtl/sram_access_arbiter.sv
// Two-port arbiter and pin sequencer for one external async SRAM.
// Optional starvation guard for port 1: SRAM_ARB_STARVE_GUARD_EN.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  sram_arb_if.slave         bus,
  inout  wire  [DATA_W-1:0] sram_DQ,
  output logic [ADDR_W-1:0] sram_ADDR,
  output logic              sram_LB_N,
  output logic              sram_UB_N,
  output logic              sram_CE_N,
  output logic              sram_OE_N,
  output logic              sram_WE_N
);

  localparam int CW = $clog2(ACCESS_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              own_q, own_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        be_q, be_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] dq_in;

  logic gnt0, gnt1;
  logic take0, take1, force1;
  logic last, acc_nxt;
  logic ce_n_d, oe_n_d, we_n_d;
  logic lb_n_d, ub_n_d, dq_oe_d;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;

  assign force1 = bus.p1_req & (starve_q >= SLIM);

  always_comb begin
    starve_d = starve_q;
    if (!bus.p1_req || gnt1) begin
      starve_d = '0;
    end else if (gnt0 && starve_q < SLIM) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) starve_q <= '0;
    else                starve_q <= starve_d;
  end
`else
  assign force1 = 1'b0;
`endif

  assign last  = (cnt_q == LAST);
  assign take0 = bus.p0_req & ~force1;
  assign take1 = bus.p1_req & ~take0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          take0: begin
            gnt0   = 1'b1;
            own_d  = PORT0;
            we_d   = 1'b0;
            addr_d = bus.p0_addr;
            be_d   = 2'b11;
          end
          take1: begin
            gnt1    = 1'b1;
            own_d   = PORT1;
            we_d    = bus.p1_we;
            addr_d  = bus.p1_addr;
            wdata_d = bus.p1_wdata;
            be_d    = bus.p1_we ? bus.p1_be : 2'b11;
          end
          default: ;
        endcase
        if (take0 || take1) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (last) state_d = TURN;
        else      cnt_d   = cnt_q + 1'b1;
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data is captured on the final access cycle, presented in TURN
  always_comb begin
    rd0_d = rd0_q;
    rd1_d = rd1_q;
    if (state_q == ACCESS && last && !we_q) begin
      if (own_q == PORT1) rd1_d = dq_in;
      else                rd0_d = dq_in;
    end
  end

  // Pin values are computed one cycle ahead and registered in sram_pin_io
  always_comb begin
    acc_nxt = (state_d == ACCESS);
    ce_n_d  = ~acc_nxt;
    oe_n_d  = ~(acc_nxt & ~we_d);
    we_n_d  = ~(acc_nxt & we_d & (cnt_d != LAST));
    lb_n_d  = ~(acc_nxt & be_d[0]);
    ub_n_d  = ~(acc_nxt & be_d[1]);
    dq_oe_d = acc_nxt & we_d;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      own_q   <= PORT0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 2'b00;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign bus.p0_gnt    = gnt0;
  assign bus.p1_gnt    = gnt1;
  assign bus.p0_rdata  = rd0_q;
  assign bus.p1_rdata  = rd1_q;
  assign bus.p0_rvalid = (state_q == TURN) & ~we_q & (own_q == PORT0);
  assign bus.p1_rvalid = (state_q == TURN) & ~we_q & (own_q == PORT1);

  sram_pin_io #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_io (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .ce_n_d   (ce_n_d),
    .oe_n_d   (oe_n_d),
    .we_n_d   (we_n_d),
    .lb_n_d   (lb_n_d),
    .ub_n_d   (ub_n_d),
    .dq_oe_d  (dq_oe_d),
    .addr_d   (addr_d),
    .dq_out_d (wdata_d),
    .ce_n     (sram_CE_N),
    .oe_n     (sram_OE_N),
    .we_n     (sram_WE_N),
    .lb_n     (sram_LB_N),
    .ub_n     (sram_UB_N),
    .addr     (sram_ADDR),
    .dq_in    (dq_in),
    .dq       (sram_DQ)
  );

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter with a behavioural SRAM.
// Honours SRAM_ARB_STARVE_GUARD_EN to pick the expected arbitration.
module tb_sram_access_arbiter;

  logic        clk;
  logic        rst_n;
  wire  [15:0] sram_DQ;
  logic [19:0] sram_ADDR;
  logic        sram_LB_N, sram_UB_N;
  logic        sram_CE_N, sram_OE_N, sram_WE_N;

  sram_arb_if #(.ADDR_W(20), .DATA_W(16)) bus ();

  sram_access_arbiter #(
    .ADDR_W        (20),
    .DATA_W        (16),
    .ACCESS_CYCLES (2),
    .STARVE_LIMIT  (8)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus),
    .sram_DQ       (sram_DQ),
    .sram_ADDR     (sram_ADDR),
    .sram_LB_N     (sram_LB_N),
    .sram_UB_N     (sram_UB_N),
    .sram_CE_N     (sram_CE_N),
    .sram_OE_N     (sram_OE_N),
    .sram_WE_N     (sram_WE_N)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM, 256 words aliased on the low address byte
  logic [15:0] mem [256];
  logic [15:0] mrd;
  assign mrd     = mem[sram_ADDR[7:0]];
  assign sram_DQ = (!sram_CE_N && !sram_OE_N && sram_WE_N) ? mrd : 'z;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'hBEEF;
    mem[8'hFF] = 16'hA5C3;
  end

  always @(posedge clk) begin
    if (!sram_CE_N && !sram_WE_N) begin
      if (!sram_LB_N) mem[sram_ADDR[7:0]][7:0]  = sram_DQ[7:0];
      if (!sram_UB_N) mem[sram_ADDR[7:0]][15:8] = sram_DQ[15:8];
    end
  end

  typedef struct packed {
    int          cyc;
    int          kind;
    logic [15:0] data;
  } ev_t;

  typedef struct packed {
    int          cyc;
    logic [4:0]  pins;
    logic [4:0]  mask;
    logic        chk_addr;
    logic [19:0] addr;
  } pin_t;

  ev_t  exq[$];
  pin_t pq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic exp_ev(int k, int c, logic [15:0] d);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.data = d;
    exq.push_back(e);
  endtask

  task automatic exp_pin(int c, logic [4:0] p, logic [4:0] m,
                         logic ca, logic [19:0] a);
    pin_t x;
    x.cyc      = c;
    x.pins     = p;
    x.mask     = m;
    x.chk_addr = ca;
    x.addr     = a;
    pq.push_back(x);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: events are {0:gnt0, 1:gnt1, 2:rvalid0, 3:rvalid1}
  always @(negedge clk) begin : mon
    logic [3:0]  evs;
    logic [15:0] d;
    logic [4:0]  pv;
    ev_t         e;
    pin_t        p;
    if (rst_n) begin
      evs = {bus.p1_rvalid, bus.p0_rvalid, bus.p1_gnt, bus.p0_gnt};
      for (int k = 0; k < 4; k++) begin
        if (evs[k]) begin
          checks++;
          d = (k == 2) ? bus.p0_rdata : (k == 3) ? bus.p1_rdata : 16'h0;
          if (exq.size() == 0) begin
            errors++;
            $display("FAIL ev_unexpected: kind %0d at cycle %0d, none required",
                     k, cyc);
          end else begin
            e = exq.pop_front();
            if (e.kind != k || e.cyc != cyc || d != e.data) begin
              errors++;
              $display("FAIL ev: got kind %0d cyc %0d data %h, required kind %0d cyc %0d data %h",
                       k, cyc, d, e.kind, e.cyc, e.data);
            end
          end
        end
      end
      pv = {sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N};
      if (pq.size() != 0 && pq[0].cyc == cyc) begin
        p = pq.pop_front();
        checks++;
        if ((((pv ^ p.pins) & p.mask) != 5'b0) ||
            (p.chk_addr && sram_ADDR != p.addr)) begin
          errors++;
          $display("FAIL pins cyc %0d: got ce/oe/we/lb/ub %b addr %h, required %b (mask %b) addr %h",
                   cyc, pv, sram_ADDR, p.pins, p.mask, p.addr);
        end
      end
      if (!sram_OE_N) begin
        checks++;
        if (!sram_WE_N) begin
          errors++;
          $display("FAIL oe_we_overlap cyc %0d: got WE_N 0 with OE_N 0, required WE_N 1",
                   cyc);
        end
      end
    end
  end

  int T;

  initial begin
    rst_n        = 1'b0;
    bus.p0_req   = 1'b0;
    bus.p0_addr  = '0;
    bus.p1_req   = 1'b0;
    bus.p1_we    = 1'b0;
    bus.p1_addr  = '0;
    bus.p1_wdata = '0;
    bus.p1_be    = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("rst_ce_n", sram_CE_N, 1);
    chk("rst_oe_n", sram_OE_N, 1);
    chk("rst_we_n", sram_WE_N, 1);
    chk("rst_lanes", {sram_UB_N, sram_LB_N}, 2'b11);
    chk("rst_addr", sram_ADDR, 0);
    chk("rst_gnt", {bus.p1_gnt, bus.p0_gnt}, 0);
    chk("rst_rvalid", {bus.p1_rvalid, bus.p0_rvalid}, 0);
    chk("rst_rdata", {bus.p1_rdata, bus.p0_rdata}, 0);

    // p0 read of a preloaded word
    T = cyc + 2;
    wait_cyc(T);
    bus.p0_req  = 1'b1;
    bus.p0_addr = 20'h00010;
    exp_ev(0, T, 16'h0);
    exp_ev(2, T + 3, 16'hBEEF);
    exp_pin(T,     5'b11111, 5'b11111, 1'b1, 20'h00000);
    exp_pin(T + 1, 5'b00100, 5'b11111, 1'b1, 20'h00010);
    exp_pin(T + 2, 5'b00100, 5'b11111, 1'b1, 20'h00010);
    exp_pin(T + 3, 5'b11100, 5'b11100, 1'b0, 20'h0);
    wait_cyc(T + 1);
    bus.p0_req = 1'b0;
    wait_cyc(T + 5);

    // p1 lower-byte write at the top address
    T = cyc + 1;
    wait_cyc(T);
    bus.p1_req   = 1'b1;
    bus.p1_we    = 1'b1;
    bus.p1_addr  = 20'hFFFFF;
    bus.p1_wdata = 16'h1234;
    bus.p1_be    = 2'b01;
    exp_ev(1, T, 16'h0);
    exp_pin(T + 1, 5'b01001, 5'b11111, 1'b1, 20'hFFFFF);
    exp_pin(T + 2, 5'b01101, 5'b11111, 1'b1, 20'hFFFFF);
    exp_pin(T + 3, 5'b11100, 5'b11100, 1'b0, 20'h0);
    wait_cyc(T + 1);
    bus.p1_req = 1'b0;
    bus.p1_we  = 1'b0;
    wait_cyc(T + 5);
    chk("byte_write_mem", mem[8'hFF], 16'hA534);

    // simultaneous requests: port 0 first, port 1 in the next IDLE
    T = cyc + 1;
    wait_cyc(T);
    bus.p0_req  = 1'b1;
    bus.p0_addr = 20'h00010;
    bus.p1_req  = 1'b1;
    bus.p1_we   = 1'b0;
    bus.p1_addr = 20'hFFFFF;
    bus.p1_be   = 2'b00;
    exp_ev(0, T, 16'h0);
    exp_ev(2, T + 3, 16'hBEEF);
    exp_ev(1, T + 4, 16'h0);
    exp_ev(3, T + 7, 16'hA534);
    exp_pin(T + 5, 5'b00100, 5'b11111, 1'b1, 20'hFFFFF);
    wait_cyc(T + 1);
    bus.p0_req = 1'b0;
    wait_cyc(T + 5);
    bus.p1_req = 1'b0;
    wait_cyc(T + 9);

    // write then read-back of the same word
    T = cyc + 1;
    wait_cyc(T);
    bus.p1_req   = 1'b1;
    bus.p1_we    = 1'b1;
    bus.p1_addr  = 20'h00030;
    bus.p1_wdata = 16'h5A5A;
    bus.p1_be    = 2'b11;
    exp_ev(1, T, 16'h0);
    exp_pin(T + 1, 5'b01000, 5'b11111, 1'b1, 20'h00030);
    exp_ev(0, T + 4, 16'h0);
    exp_ev(2, T + 7, 16'h5A5A);
    exp_pin(T + 5, 5'b00100, 5'b11111, 1'b1, 20'h00030);
    wait_cyc(T + 1);
    bus.p1_req  = 1'b0;
    bus.p1_we   = 1'b0;
    bus.p0_req  = 1'b1;
    bus.p0_addr = 20'h00030;
    wait_cyc(T + 5);
    bus.p0_req = 1'b0;
    wait_cyc(T + 9);

    // port 0 hogging while port 1 waits
    T = cyc + 1;
    wait_cyc(T);
    bus.p0_req  = 1'b1;
    bus.p0_addr = 20'h00010;
    bus.p1_req  = 1'b1;
    bus.p1_we   = 1'b0;
    bus.p1_addr = 20'hFFFFF;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 8; k++) begin
      exp_ev(0, T + 4 * k, 16'h0);
      exp_ev(2, T + 4 * k + 3, 16'hBEEF);
    end
    exp_ev(1, T + 32, 16'h0);
    exp_ev(3, T + 35, 16'hA534);
    wait_cyc(T + 33);
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    wait_cyc(T + 37);
`else
    for (int k = 0; k < 10; k++) begin
      exp_ev(0, T + 4 * k, 16'h0);
      exp_ev(2, T + 4 * k + 3, 16'hBEEF);
    end
    exp_ev(1, T + 40, 16'h0);
    exp_ev(3, T + 43, 16'hA534);
    wait_cyc(T + 37);
    bus.p0_req = 1'b0;
    wait_cyc(T + 41);
    bus.p1_req = 1'b0;
    wait_cyc(T + 45);
`endif

    // reset in the middle of a write access
    T = cyc + 1;
    wait_cyc(T);
    bus.p1_req   = 1'b1;
    bus.p1_we    = 1'b1;
    bus.p1_addr  = 20'h00020;
    bus.p1_wdata = 16'hFFFF;
    bus.p1_be    = 2'b11;
    exp_ev(1, T, 16'h0);
    wait_cyc(T + 1);
    bus.p1_req = 1'b0;
    bus.p1_we  = 1'b0;
    #2;
    chk("pre_rst_we_n", sram_WE_N, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we_n", sram_WE_N, 1);
    chk("mid_rst_ce_n", sram_CE_N, 1);
    chk("mid_rst_oe_n", sram_OE_N, 1);
    chk("mid_rst_addr", sram_ADDR, 0);
    wait_cyc(T + 3);
    rst_n = 1'b1;
    chk("post_rst_rdata", {bus.p1_rdata, bus.p0_rdata}, 0);
    wait_cyc(T + 12);
    chk("aborted_write_mem", mem[8'h20], 16'h0000);
    chk("post_rst_ce_n", sram_CE_N, 1);

    chk("events_left", exq.size(), 0);
    chk("pins_left", pq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
